// File: rtl/bp_dcache_lce_mem_sweeper.sv
// ==== bp_dcache_lce_mem_sweeper : walks dcache tag/stat memories issuing clear/invalidate packets (rev 1.0) ====
`default_nettype none

module bp_dcache_lce_mem_sweeper #(
  parameter int sets_p = 64,
  parameter int ways_p = 8
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic                                      sweep_v_i,
  input  logic                                      sweep_mode_i,
  output logic                                      sweep_ready_o,
  output logic                                      sweep_done_o,
  output logic                                      busy_o,
  output logic                                      tag_mem_pkt_v_o,
  output logic [((sets_p > 1) ? $clog2(sets_p) : 1)-1:0] tag_mem_pkt_index_o,
  output logic [((ways_p > 1) ? $clog2(ways_p) : 1)-1:0] tag_mem_pkt_way_o,
  output logic [1:0]                                tag_mem_pkt_opcode_o,
  input  logic                                      tag_mem_pkt_yumi_i,
  output logic                                      stat_mem_pkt_v_o,
  output logic [((sets_p > 1) ? $clog2(sets_p) : 1)-1:0] stat_mem_pkt_index_o,
  output logic [1:0]                                stat_mem_pkt_opcode_o,
  input  logic                                      stat_mem_pkt_yumi_i
);

  localparam int idx_w = (sets_p > 1) ? $clog2(sets_p) : 1;
  localparam int way_w = (ways_p > 1) ? $clog2(ways_p) : 1;
  localparam logic [idx_w-1:0] last_set_c = idx_w'(sets_p - 1);
  localparam logic [way_w-1:0] last_way_c = way_w'(ways_p - 1);

  typedef enum logic [1:0] {
    e_reset = 2'd0,
    e_clear = 2'd1,
    e_inv   = 2'd2,
    e_idle  = 2'd3
  } state_e;

  state_e           state_q, state_n;
  logic [idx_w-1:0] set_q, set_n;
  logic [way_w-1:0] way_q, way_n;
  logic             tag_sent_q, tag_sent_n;
  logic             stat_sent_q, stat_sent_n;
  logic             done_q, done_n;

  logic sweeping;
  logic tag_fire, stat_fire;
  logic tag_step_done, stat_step_done;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= e_reset;
      set_q       <= '0;
      way_q       <= '0;
      tag_sent_q  <= 1'b0;
      stat_sent_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      set_q       <= set_n;
      way_q       <= way_n;
      tag_sent_q  <= tag_sent_n;
      stat_sent_q <= stat_sent_n;
      done_q      <= done_n;
    end
  end

  assign sweeping  = (state_q == e_clear) || (state_q == e_inv);
  assign tag_fire  = tag_mem_pkt_v_o && tag_mem_pkt_yumi_i;
  assign stat_fire = stat_mem_pkt_v_o && stat_mem_pkt_yumi_i;

  // In invalidate mode the tag side of a step finishes only with the last way.
  assign tag_step_done  = tag_sent_q
                       || (tag_fire && ((state_q == e_clear) || (way_q == last_way_c)));
  assign stat_step_done = stat_sent_q || stat_fire;

  always_comb begin
    state_n     = state_q;
    set_n       = set_q;
    way_n       = way_q;
    tag_sent_n  = tag_sent_q;
    stat_sent_n = stat_sent_q;
    done_n      = 1'b0;

    case (state_q)
      e_reset: begin
        state_n     = e_clear;
        set_n       = '0;
        way_n       = '0;
        tag_sent_n  = 1'b0;
        stat_sent_n = 1'b0;
      end

      e_clear, e_inv: begin
        if (tag_fire && (state_q == e_inv) && (way_q != last_way_c)) begin
          way_n = way_q + way_w'(1);
        end
        if (tag_step_done && stat_step_done) begin
          tag_sent_n  = 1'b0;
          stat_sent_n = 1'b0;
          way_n       = '0;
          if (set_q == last_set_c) begin
            state_n = e_idle;
            set_n   = '0;
            done_n  = 1'b1;
          end else begin
            set_n = set_q + idx_w'(1);
          end
        end else begin
          tag_sent_n  = tag_step_done;
          stat_sent_n = stat_step_done;
        end
      end

      e_idle: begin
        if (sweep_v_i) begin
          state_n     = sweep_mode_i ? e_inv : e_clear;
          set_n       = '0;
          way_n       = '0;
          tag_sent_n  = 1'b0;
          stat_sent_n = 1'b0;
        end
      end

      default: state_n = e_reset;
    endcase
  end

  assign tag_mem_pkt_v_o       = sweeping && !tag_sent_q;
  assign tag_mem_pkt_index_o   = set_q;
  assign tag_mem_pkt_way_o     = way_q;
  assign tag_mem_pkt_opcode_o  = (state_q == e_inv) ? 2'd1 : 2'd0;
  assign stat_mem_pkt_v_o      = sweeping && !stat_sent_q;
  assign stat_mem_pkt_index_o  = set_q;
  assign stat_mem_pkt_opcode_o = 2'd0;

  assign sweep_ready_o = (state_q == e_idle);
  assign busy_o        = (state_q != e_idle);
  assign sweep_done_o  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bp_dcache_lce_mem_sweeper.sv
// ==== tb_bp_dcache_lce_mem_sweeper : randomized/directed bench with packet-list reference model (rev 1.0) ====
`default_nettype none

module tb_bp_dcache_lce_mem_sweeper;

  localparam int sets_a = 4;
  localparam int ways_a = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: 4 sets x 2 ways
  logic       rst_a, sweep_v_a, mode_a, ready_a, done_a, busy_a;
  logic       tag_v_a, tag_yumi_a, stat_v_a, stat_yumi_a;
  logic [1:0] tag_idx_a, stat_idx_a, tag_op_a, stat_op_a;
  logic [0:0] tag_way_a;

  // instance B: 1 set x 1 way
  logic       rst_b, sweep_v_b, mode_b, ready_b, done_b, busy_b;
  logic       tag_v_b, tag_yumi_b, stat_v_b, stat_yumi_b;
  logic [0:0] tag_idx_b, stat_idx_b, tag_way_b;
  logic [1:0] tag_op_b, stat_op_b;

  bp_dcache_lce_mem_sweeper #(.sets_p(sets_a), .ways_p(ways_a)) dut_a (
    .clk_i(clk), .reset_i(rst_a), .sweep_v_i(sweep_v_a), .sweep_mode_i(mode_a),
    .sweep_ready_o(ready_a), .sweep_done_o(done_a), .busy_o(busy_a),
    .tag_mem_pkt_v_o(tag_v_a), .tag_mem_pkt_index_o(tag_idx_a), .tag_mem_pkt_way_o(tag_way_a),
    .tag_mem_pkt_opcode_o(tag_op_a), .tag_mem_pkt_yumi_i(tag_yumi_a),
    .stat_mem_pkt_v_o(stat_v_a), .stat_mem_pkt_index_o(stat_idx_a),
    .stat_mem_pkt_opcode_o(stat_op_a), .stat_mem_pkt_yumi_i(stat_yumi_a)
  );

  bp_dcache_lce_mem_sweeper #(.sets_p(1), .ways_p(1)) dut_b (
    .clk_i(clk), .reset_i(rst_b), .sweep_v_i(sweep_v_b), .sweep_mode_i(mode_b),
    .sweep_ready_o(ready_b), .sweep_done_o(done_b), .busy_o(busy_b),
    .tag_mem_pkt_v_o(tag_v_b), .tag_mem_pkt_index_o(tag_idx_b), .tag_mem_pkt_way_o(tag_way_b),
    .tag_mem_pkt_opcode_o(tag_op_b), .tag_mem_pkt_yumi_i(tag_yumi_b),
    .stat_mem_pkt_v_o(stat_v_b), .stat_mem_pkt_index_o(stat_idx_b),
    .stat_mem_pkt_opcode_o(stat_op_b), .stat_mem_pkt_yumi_i(stat_yumi_b)
  );

  int checks = 0;
  int failures = 0;

  // consumed packets, keyed tag = idx*1000 + way*10 + op, stat = idx*10 + op
  int tq_a[$], sq_a[$], tq_b[$], sq_b[$];
  int done_cnt_a = 0, done_cnt_b = 0;
  bit rand_a = 0;
  int hold_a = 0, hold_set = 0;

  int prev_tkey = 0, prev_skey = 0;
  bit prev_tv = 0, prev_sv = 0, prev_tcons = 0, prev_scons = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Consumer model: drives yumis on the falling edge and logs every handshake.
  always @(negedge clk) begin
    int  tkey, skey;
    bit  ty, sy;
    tkey = int'(tag_idx_a) * 1000 + int'(tag_way_a) * 10 + int'(tag_op_a);
    skey = int'(stat_idx_a) * 10 + int'(stat_op_a);
    if (!rst_a && prev_tv && !prev_tcons) begin
      check("tag_hold_v", int'(tag_v_a), 1);
      check("tag_hold_pkt", tkey, prev_tkey);
    end
    if (!rst_a && prev_sv && !prev_scons) begin
      check("stat_hold_v", int'(stat_v_a), 1);
      check("stat_hold_pkt", skey, prev_skey);
    end
    ty = rand_a ? 1'($urandom_range(0, 1)) : 1'b1;
    sy = rand_a ? 1'($urandom_range(0, 1)) : 1'b1;
    if (hold_a > 0 && stat_v_a && int'(stat_idx_a) == hold_set) begin
      sy = 1'b0;
      hold_a--;
    end
    tag_yumi_a  = ty;
    stat_yumi_a = sy;
    if (tag_v_a && ty) tq_a.push_back(tkey);
    if (stat_v_a && sy) sq_a.push_back(skey);
    if (done_a) done_cnt_a++;
    prev_tv = tag_v_a; prev_sv = stat_v_a;
    prev_tkey = tkey;  prev_skey = skey;
    prev_tcons = tag_v_a && ty; prev_scons = stat_v_a && sy;

    tag_yumi_b  = 1'b1;
    stat_yumi_b = 1'b1;
    if (tag_v_b) tq_b.push_back(int'(tag_idx_b) * 1000 + int'(tag_way_b) * 10 + int'(tag_op_b));
    if (stat_v_b) sq_b.push_back(int'(stat_idx_b) * 10 + int'(stat_op_b));
    if (done_b) done_cnt_b++;
  end

  // Reference: a clear sweep visits sets in order; an invalidate sweep visits every (set, way).
  task automatic check_seq_a(input int mode);
    int nt, e;
    nt = mode ? sets_a * ways_a : sets_a;
    check("tag_count", tq_a.size(), nt);
    check("stat_count", sq_a.size(), sets_a);
    for (int i = 0; i < nt && i < tq_a.size(); i++) begin
      e = mode ? (i / ways_a) * 1000 + (i % ways_a) * 10 + 1 : i * 1000;
      check("tag_pkt", tq_a[i], e);
    end
    for (int i = 0; i < sets_a && i < sq_a.size(); i++) check("stat_pkt", sq_a[i], i * 10);
  endtask

  task automatic clear_a();
    tq_a.delete(); sq_a.delete(); done_cnt_a = 0;
  endtask

  task automatic wait_done_a(input int bound, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      sweep_v_a = 1'b0;
    end while (!done_a && cyc < bound);
    check("done_timeout", int'(done_a), 1);
    check("busy_at_done", int'(busy_a), 0);
  endtask

  initial begin
    int first, cyc;
    rst_a = 1; rst_b = 1; sweep_v_a = 0; sweep_v_b = 0; mode_a = 0; mode_b = 0;
    tag_yumi_a = 0; stat_yumi_a = 0; tag_yumi_b = 0; stat_yumi_b = 0;
    repeat (3) @(negedge clk);
    check("rst_tag_v", int'(tag_v_a), 0);
    check("rst_stat_v", int'(stat_v_a), 0);
    check("rst_ready", int'(ready_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_busy", int'(busy_a), 1);
    check("rst_b_tag_v", int'(tag_v_b), 0);

    // auto-init sweep; a request pulsed mid-sweep must be dropped
    clear_a(); tq_b.delete(); sq_b.delete(); done_cnt_b = 0;
    rst_a = 0; rst_b = 0;
    first = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done_a && first == 0) first = c;
      sweep_v_a = (c == 2);
      mode_a = 1'b1;
    end
    check("init_done_cycle", first, 5);
    check("init_done_count", done_cnt_a, 1);
    check("init_ready", int'(ready_a), 1);
    check("init_busy", int'(busy_a), 0);
    check_seq_a(0);
    check("b_init_done", done_cnt_b, 1);
    check("b_init_tags", tq_b.size(), 1);
    if (tq_b.size() > 0) check("b_init_tag", tq_b[0], 0);
    check("b_init_stats", sq_b.size(), 1);

    // invalidate sweep, yumis always high
    clear_a();
    mode_a = 1; sweep_v_a = 1;
    wait_done_a(100, cyc);
    check("inv_done_cycle", cyc, sets_a * ways_a + 1);
    @(negedge clk);
    check("inv_done_pulse", int'(done_a), 0);
    check("inv_ready", int'(ready_a), 1);
    check("inv_done_count", done_cnt_a, 1);
    check_seq_a(1);

    // clear sweep with stat yumi withheld 3 cycles on set 2
    clear_a();
    hold_set = 2; hold_a = 3;
    mode_a = 0; sweep_v_a = 1;
    wait_done_a(100, cyc);
    check("hold_done_cycle", cyc, sets_a + 3 + 1);
    @(negedge clk);
    check("hold_used", hold_a, 0);
    check("hold_done_count", done_cnt_a, 1);
    check_seq_a(0);

    // invalidate sweep under random independent backpressure
    clear_a();
    rand_a = 1;
    mode_a = 1; sweep_v_a = 1;
    wait_done_a(600, cyc);
    @(negedge clk);
    rand_a = 0;
    check("rand_done_count", done_cnt_a, 1);
    check_seq_a(1);
    @(negedge clk);

    // reset while on set 2 of an invalidate sweep
    mode_a = 1; sweep_v_a = 1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      sweep_v_a = 0;
    end while (!(tag_v_a && tag_idx_a == 2'd2) && cyc < 50);
    check("abort_reach_set2", int'(tag_idx_a), 2);
    done_cnt_a = 0;
    rst_a = 1;
    @(negedge clk);
    check("abort_tag_v", int'(tag_v_a), 0);
    check("abort_stat_v", int'(stat_v_a), 0);
    check("abort_busy", int'(busy_a), 1);
    check("abort_done", int'(done_a), 0);
    clear_a();
    rst_a = 0;
    wait_done_a(50, cyc);
    check("abort_restart_cycle", cyc, sets_a + 1);
    @(negedge clk);
    check("abort_done_count", done_cnt_a, 1);
    check_seq_a(0);

    // single set, single way invalidate
    tq_b.delete(); sq_b.delete(); done_cnt_b = 0;
    mode_b = 1; sweep_v_b = 1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      sweep_v_b = 0;
    end while (!done_b && cyc < 20);
    check("b_inv_done_cycle", cyc, 2);
    @(negedge clk);
    check("b_inv_done_count", done_cnt_b, 1);
    check("b_inv_tags", tq_b.size(), 1);
    if (tq_b.size() > 0) check("b_inv_tag", tq_b[0], 1);
    check("b_inv_stats", sq_b.size(), 1);
    if (sq_b.size() > 0) check("b_inv_stat", sq_b[0], 0);
    check("b_ready", int'(ready_b), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
